mem_stage: RTL

Memory-access stage directly downstream of the execute stage; consumes the EX/MEM register outputs (ALU result, store data, write-back control, memory flags).
Performs aligned loads/stores over a single-outstanding data-bus handshake, formats load data, and detects misaligned and bus-error exceptions.
Holds the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_pkg.sv | 75 +++++++
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage_memwb_reg.sv | 72 +++++++
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: flag bit positions, FSM states,
// exception cause codes and the load/store lane helpers.
package mem_stage_pkg;

    localparam int FLAG_BYTE     = 0;
    localparam int FLAG_HALF     = 1;
    localparam int FLAG_WORD     = 2;
    localparam int FLAG_UNSIGNED = 3;
    localparam int FLAG_READ     = 4;
    localparam int FLAG_WRITE    = 5;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE           = 2'd0;
    localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'd1;
    localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_BUS_ERR        = 2'd3;

    function automatic logic [3:0] lane_sel(input logic is_byte, input logic is_half,
                                            input logic [1:0] lo);
        logic [3:0] sel;
        if (is_byte) begin
            sel = 4'b0001 << lo;
        end else if (is_half) begin
            sel = 4'b0011 << lo;
        end else begin
            sel = 4'b1111;
        end
        return sel;
    endfunction

    function automatic logic [31:0] store_lanes(input logic is_byte, input logic is_half,
                                                input logic [31:0] data);
        logic [31:0] res;
        if (is_byte) begin
            res = {4{data[7:0]}};
        end else if (is_half) begin
            res = {2{data[15:0]}};
        end else begin
            res = data;
        end
        return res;
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] rdata, input logic [1:0] lo,
                                                input logic is_byte, input logic is_half,
                                                input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        if (is_byte) begin
            res = {{24{b[7] & ~is_unsigned}}, b};
        end else if (is_half) begin
            res = {{16{h[15] & ~is_unsigned}}, h};
        end else begin
            res = rdata;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding data-bus port between the memory stage (master) and memory (slave).
interface mem_stage_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output address, wdata, sel, we, cyc, input rdata, ack, err);
    modport slave  (input address, wdata, sel, we, cyc, output rdata, ack, err);
endinterface

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register: flush inserts a bubble, hold freezes, otherwise it captures.
module memwb_reg
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  cause_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_instruction_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic [31:0] wb_wdata_o,
    output logic [1:0]  wb_exc_cause_o,
    output logic [31:0] wb_bad_addr_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [1:0]  cause_q;
    logic [31:0] bad_q;

    // Register update with flush > hold > load priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            waddr_q <= 5'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            cause_q <= CAUSE_NONE;
            bad_q   <= 32'h0;
        end else if (flush_i) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            waddr_q <= 5'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            cause_q <= CAUSE_NONE;
            bad_q   <= 32'h0;
        end else if (!hold_i) begin
            pc_q    <= pc_i;
            instr_q <= instruction_i;
            waddr_q <= waddr_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
            cause_q <= cause_i;
            bad_q   <= bad_addr_i;
        end
    end

    assign wb_pc_o          = pc_q;
    assign wb_instruction_o = instr_q;
    assign wb_waddr_o       = waddr_q;
    assign wb_we_o          = we_q;
    assign wb_wdata_o       = wdata_q;
    assign wb_exc_cause_o   = cause_q;
    assign wb_bad_addr_o    = bad_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues aligned loads/stores on the data bus, formats load data,
// flags misaligned/bus-error exceptions and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_stall_i,
    input  logic        mem_flush_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_instruction_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_store_data_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [5:0]  mem_mem_flags_i,
    input  logic        mem_mem_ex_sel_i,
    mem_stage_if.master dport,
    output logic        mem_request_stall_o,
    output logic [31:0] mem_fwd_dat_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_instruction_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic [31:0] wb_wdata_o,
    output logic [1:0]  wb_exc_cause_o,
    output logic [31:0] wb_bad_addr_o
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_err_q, buf_err_d;

    logic        is_byte_s, is_half_s, is_word_s, is_unsigned_s, is_read_s, is_write_s;
    logic        access_s, misaligned_s, aligned_acc_s;
    logic        stall_s, resp_err_s;
    logic [31:0] resp_data_s, load_fmt_s;
    logic [1:0]  cause_s;
    logic        exc_s;

    assign is_byte_s     = mem_mem_flags_i[FLAG_BYTE];
    assign is_half_s     = mem_mem_flags_i[FLAG_HALF];
    assign is_word_s     = mem_mem_flags_i[FLAG_WORD];
    assign is_unsigned_s = mem_mem_flags_i[FLAG_UNSIGNED];
    assign is_read_s     = mem_mem_flags_i[FLAG_READ];
    assign is_write_s    = mem_mem_flags_i[FLAG_WRITE];
    assign access_s      = is_read_s | is_write_s;

    // Alignment check on the effective address for the selected access size.
    always_comb begin
        misaligned_s = 1'b0;
        if (is_byte_s) begin
            misaligned_s = 1'b0;
        end else if (is_half_s) begin
            misaligned_s = mem_result_i[0];
        end else if (is_word_s) begin
            misaligned_s = (mem_result_i[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
    end

    assign aligned_acc_s = access_s & ~misaligned_s;

    // Bus FSM state and registered bus outputs, plus the response buffer used by HOLD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            sel_q      <= 4'h0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            buf_data_q <= 32'h0;
            buf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            buf_data_q <= buf_data_d;
            buf_err_q  <= buf_err_d;
        end
    end

    // Next-state, bus request and response selection.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        stall_s     = 1'b0;
        resp_data_s = dport.rdata;
        resp_err_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_acc_s && !mem_flush_i) begin
                    stall_s = 1'b1;
                    state_d = ST_WAIT;
                    cyc_d   = 1'b1;
                    we_d    = is_write_s;
                    addr_d  = {mem_result_i[31:2], 2'b00};
                    sel_d   = lane_sel(is_byte_s, is_half_s, mem_result_i[1:0]);
                    wdata_d = is_write_s ? store_lanes(is_byte_s, is_half_s, mem_store_data_i)
                                         : 32'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dport.ack || dport.err) begin
                    resp_err_s = dport.err;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    addr_d     = 32'h0;
                    wdata_d    = 32'h0;
                    if (mem_flush_i) begin
                        state_d = ST_IDLE;
                    end else if (mem_stall_i) begin
                        state_d    = ST_HOLD;
                        buf_data_d = dport.rdata;
                        buf_err_d  = dport.err;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    stall_s = 1'b1;
                    state_d = mem_flush_i ? ST_ABORT : ST_WAIT;
                end
            end
            ST_HOLD: begin
                resp_data_s = buf_data_q;
                resp_err_s  = buf_err_q;
                if (mem_flush_i || !mem_stall_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ABORT: begin
                // The squashed access must still finish on the bus; its data is dropped.
                stall_s = 1'b1;
                if (dport.ack || dport.err) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    addr_d  = 32'h0;
                    wdata_d = 32'h0;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = 4'h0;
                addr_d  = 32'h0;
                wdata_d = 32'h0;
            end
        endcase
    end

    assign load_fmt_s = load_format(resp_data_s, mem_result_i[1:0], is_byte_s, is_half_s,
                                    is_unsigned_s);

    // Exception cause for the instruction currently in MEM.
    always_comb begin
        cause_s = CAUSE_NONE;
        if (access_s && misaligned_s) begin
            cause_s = is_write_s ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
        end else if (resp_err_s) begin
            cause_s = CAUSE_BUS_ERR;
        end else begin
            cause_s = CAUSE_NONE;
        end
    end

    assign exc_s               = (cause_s != CAUSE_NONE);
    assign mem_request_stall_o = stall_s;
    assign mem_fwd_dat_o       = mem_mem_ex_sel_i ? load_fmt_s : mem_result_i;

    assign dport.address = addr_q;
    assign dport.wdata   = wdata_q;
    assign dport.sel     = sel_q;
    assign dport.we      = we_q;
    assign dport.cyc     = cyc_q;

    memwb_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_memwb (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (mem_flush_i),
        .hold_i           (mem_stall_i | stall_s),
        .pc_i             (mem_pc_i),
        .instruction_i    (mem_instruction_i),
        .waddr_i          (mem_waddr_i),
        .we_i             (mem_we_i & ~exc_s),
        .wdata_i          (mem_fwd_dat_o),
        .cause_i          (cause_s),
        .bad_addr_i       (exc_s ? mem_result_i : 32'h0),
        .wb_pc_o          (wb_pc_o),
        .wb_instruction_o (wb_instruction_o),
        .wb_waddr_o       (wb_waddr_o),
        .wb_we_o          (wb_we_o),
        .wb_wdata_o       (wb_wdata_o),
        .wb_exc_cause_o   (wb_exc_cause_o),
        .wb_bad_addr_o    (wb_bad_addr_o)
    );

endmodule
